// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-syncs a WIDTH-bit predictor, locks, then counts bit errors.
// Latency: locked/err_pulse/counters update the cycle after a beat; no backpressure, beats are in_valid-qualified.
module prbs_checker #(
    parameter int WIDTH       = 5,
    parameter int LOCK_COUNT  = 16,
    parameter int WINDOW      = 64,
    parameter int UNLOCK_ERRS = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] taps,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);
    localparam int FW = $clog2(WIDTH + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(WINDOW + 1);
    localparam int EW = $clog2(UNLOCK_ERRS + 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] h, h_nxt;
    logic [FW-1:0]    fill, fill_nxt;
    logic [MW-1:0]    match, match_nxt;
    logic [WW-1:0]    win_cnt, win_cnt_nxt;
    logic [EW-1:0]    win_err, win_err_nxt;
    logic             pulse_nxt;
    logic [CNT_W-1:0] ec_nxt, bc_nxt;
    logic             pred, mismatch;

    assign pred     = ^(taps & h);
    assign mismatch = in_bit ^ pred;
    assign locked   = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEARCH;
            h         <= '0;
            fill      <= '0;
            match     <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            state     <= state_nxt;
            h         <= h_nxt;
            fill      <= fill_nxt;
            match     <= match_nxt;
            win_cnt   <= win_cnt_nxt;
            win_err   <= win_err_nxt;
            err_pulse <= pulse_nxt;
            err_count <= ec_nxt;
            bit_count <= bc_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        h_nxt       = h;
        fill_nxt    = fill;
        match_nxt   = match;
        win_cnt_nxt = win_cnt;
        win_err_nxt = win_err;
        pulse_nxt   = 1'b0;
        ec_nxt      = err_count;
        bc_nxt      = bit_count;

        if (in_valid) begin
            case (state)
                SEARCH: begin
                    h_nxt = {h[WIDTH-2:0], in_bit};
                    if (fill != FW'(WIDTH)) begin
                        fill_nxt = fill + FW'(1);
                    // an all-zero history predicts zeros forever, so it never earns lock
                    end else if (mismatch || (h == '0)) begin
                        match_nxt = '0;
                    end else if (match == MW'(LOCK_COUNT - 1)) begin
                        state_nxt   = LOCKED;
                        match_nxt   = '0;
                        win_cnt_nxt = '0;
                        win_err_nxt = '0;
                    end else begin
                        match_nxt = match + MW'(1);
                    end
                end
                LOCKED: begin
                    // free-running reference: a flipped input bit never pollutes the history
                    h_nxt = {h[WIDTH-2:0], pred};
                    if (bit_count != '1) bc_nxt = bit_count + CNT_W'(1);
                    if (mismatch) begin
                        pulse_nxt = 1'b1;
                        if (err_count != '1) ec_nxt = err_count + CNT_W'(1);
                    end
                    if (mismatch && (win_err == EW'(UNLOCK_ERRS - 1))) begin
                        state_nxt   = SEARCH;
                        fill_nxt    = '0;
                        match_nxt   = '0;
                        win_cnt_nxt = '0;
                        win_err_nxt = '0;
                    end else begin
                        if (mismatch) win_err_nxt = win_err + EW'(1);
                        if (win_cnt == WW'(WINDOW - 1)) begin
                            win_cnt_nxt = '0;
                            win_err_nxt = '0;
                        end else begin
                            win_cnt_nxt = win_cnt + WW'(1);
                        end
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end

        if (clear) begin
            ec_nxt = '0;
            bc_nxt = '0;
        end
    end
endmodule
